gpio_arbiter: RTL and testbench
===============================

// Module: gpio_arbiter
//
// PURPOSE
//  Shares the single GPIO register port (regSel/we/di/do) between N requesters (CPU, DMA, debug).
//  Round-robin arbitration; valid/ready request handshake; registered command issue and response.
//  Optional lock lets one requester make an atomic read-modify-write sequence. Sits between the
//  bus decode / requesters and the gpio block.
//
// PARAMETERS
//  N             2    number of requesters (2..8)
//  LOCK_TIMEOUT  64   idle cycles a locked owner may hold the port before forced release (>=2)
//
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  req_valid    in   N      requester i has a command
//  req_ready    out  N      one-hot; command of requester i accepted this cycle
//  req_we       in   N      1 = write, 0 = read, per requester
//  req_sel      in   3*N    register select, requester i at [3*i+2:3*i]
//  req_wdata    in   32*N   write data, requester i at [32*i+31:32*i]
//  req_lock     in   N      hold the port after this command completes
//  rsp_valid    out  N      one-hot, one-cycle pulse: response for requester i
//  rsp_rdata    out  32     response data, valid with any rsp_valid bit
//  lock_err     out  1      one-cycle pulse: lock forcibly released by timeout
//  gpio_regSel  out  3      to gpio regSel
//  gpio_we      out  1      to gpio we
//  gpio_di      out  32     to gpio di
//  gpio_do      in   32     from gpio do (combinational read data)
//
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, unlocked, timeout counter 0; all outputs 0; pending command dropped, no rsp.
//  - FSM IDLE -> ISSUE -> RESP -> (IDLE | ISSUE).
//  - Accept (IDLE or RESP): if unlocked, winner = first i with req_valid[i] starting at rr pointer,
//    wrapping N-1 -> 0; if locked, only owner eligible, others see req_ready=0.
//    req_ready[winner]=1 that cycle (combinational from req_valid); latch we/sel/wdata/lock/id; go ISSUE.
//  - ISSUE: gpio_regSel/gpio_di driven from latch, gpio_we = latched we (exactly one cycle);
//    gpio_do captured into rsp_rdata register; go RESP. gpio_* are 0 outside ISSUE.
//  - RESP: rsp_valid[id]=1, rsp_rdata = captured value (for writes: do in the write cycle, pre-update).
//    Same cycle a new command may be accepted -> ISSUE; else IDLE. Throughput 1 cmd / 2 cycles,
//    latency accept->rsp = 2 cycles.
//  - rr pointer: on accept when unlocked, pointer = (winner+1) mod N. Unchanged while locked.
//  - Lock: accepted cmd with req_lock=1 sets owner=id, locked=1 at accept. Accepted owner cmd with
//    req_lock=0 clears locked at its RESP cycle; that cmd still completes normally.
//  - Timeout: counter increments each cycle locked and FSM not in ISSUE and owner not accepted;
//    resets on owner accept. Reaching LOCK_TIMEOUT: locked=0, lock_err pulse, counter 0;
//    other requesters eligible from the next cycle.
//  - Read-only selects (2, 5) forwarded unchanged; gpio ignores writes, response still returned.
//  - req_valid deasserted before ready: no effect, nothing latched. Multiple simultaneous valids: one grant only.
//
// STRUCTURE
//  - Shared header gpio_defs.vh: GPIO register-select constants (WR_A=0, DIR_A=1, RD_A=2,
//    WR_B=3, DIR_B=4, RD_B=5), FSM state encodings (IDLE/ISSUE/RESP), command field widths.
//  - Sub-module rr_arbiter (combinational): inputs req[N], ptr, mask-enable; outputs one-hot
//    grant and encoded index. FSM, latch, lock and timeout in gpio_arbiter.
//
// TESTING
//  1. Single read: req0 sel=0 after gpio WR_A=0xA5 -> ready0 cycle t, gpio_we=0 t+1, rsp_valid=01 rdata=0x000000A5 t+2.
//  2. Contention N=2: both valid for 4 cmds -> grants 0,1,0,1; every gpio_we pulse one cycle; rsp order matches.
//  3. Back-to-back: req1 writes sel=1 di=0xFF then sel=0 di=0x3C -> accepts 2 cycles apart; DIR_A=0xFF, ports[7:0]=0x3C.
//  4. Lock RMW: req0 read sel=0 lock=1, req1 valid throughout, req0 write sel=0 lock=0 -> req1 ready only after req0 write RESP.
//  5. Timeout LOCK_TIMEOUT=4: req0 locks then goes idle -> lock_err at 4th idle cycle, req1 granted next cycle.
//  6. Reset in ISSUE (gpio_we=1) -> next cycle all outputs 0, no rsp_valid, rr pointer 0, lock cleared.

Source files
------------

// File: rtl/gpio_arbiter_pkg.sv
// Shared definitions for the GPIO port arbiter: register selects, FSM states, field widths.
package gpio_arbiter_pkg;

    localparam int IDX_W  = 3;     // requester index width, covers up to 8 requesters
    localparam int SEL_W  = 3;
    localparam int DATA_W = 32;

    localparam logic [SEL_W-1:0] SEL_WR_A  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_DIR_A = 3'd1;
    localparam logic [SEL_W-1:0] SEL_RD_A  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_WR_B  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_DIR_B = 3'd4;
    localparam logic [SEL_W-1:0] SEL_RD_B  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Round-robin pointer advance: one past the winner, wrapping at n-1.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/gpio_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, optionally restricted by mask.
module rr_arbiter
    import gpio_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mask_en,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N-1:0] eff;

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        eff   = mask_en ? (req & mask) : req;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && eff[i] && (i == ((int'(ptr) + k) % N))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/gpio_arbiter.sv
// Shares the single GPIO register port between N requesters with round-robin arbitration,
// a two-cycle command/response pipeline and an optional lock for read-modify-write sequences.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no command in flight; a new command may be accepted
//  ST_ISSUE | latched command driven onto gpio_*; read data captured
//  ST_RESP  | response pulse to the requester; next command may be accepted
module gpio_arbiter
    import gpio_arbiter_pkg::*;
#(
    parameter int N            = 2,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N-1:0]        req_we,
    input  logic [3*N-1:0]      req_sel,
    input  logic [32*N-1:0]     req_wdata,
    input  logic [N-1:0]        req_lock,
    output logic [N-1:0]        rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                lock_err,
    output logic [2:0]          gpio_regSel,
    output logic                gpio_we,
    output logic [31:0]         gpio_di,
    input  logic [31:0]         gpio_do
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   lat_id;
    logic               lat_lock;
    logic               locked;
    logic [CNT_W-1:0]   to_cnt;

    logic [N-1:0]       grant;
    logic [IDX_W-1:0]   win_idx;
    logic               found;
    logic [N-1:0]       owner_mask;
    logic [N-1:0]       id_mask;
    logic               accept;
    logic               owner_acc;
    logic               to_inc;
    logic               to_hit;
    logic               w_we;
    logic               w_lock;
    logic [SEL_W-1:0]   w_sel;
    logic [DATA_W-1:0]  w_wdata;

    rr_arbiter #(.N(N)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .mask_en (locked),
        .mask    (owner_mask),
        .grant   (grant),
        .idx     (win_idx),
        .found   (found)
    );

    // One-hot decodes of the lock owner and the in-flight command's requester.
    always_comb begin
        owner_mask = '0;
        id_mask    = '0;
        for (int i = 0; i < N; i++) begin
            owner_mask[i] = (owner == IDX_W'(i));
            id_mask[i]    = (lat_id == IDX_W'(i));
        end
    end

    // Select the winner's command fields.
    always_comb begin
        w_we    = 1'b0;
        w_lock  = 1'b0;
        w_sel   = '0;
        w_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_we    = req_we[i];
                w_lock  = req_lock[i];
                w_sel   = req_sel[3*i +: 3];
                w_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Accept handshake and lock-timeout detection; both suppressed while reset is held.
    always_comb begin
        accept    = !reset && (state != ST_ISSUE) && found;
        req_ready = accept ? grant : '0;
        owner_acc = accept && locked;
        to_inc    = locked && (state != ST_ISSUE) && !owner_acc;
        to_hit    = to_inc && (to_cnt == CNT_W'(LOCK_TIMEOUT - 1));
        lock_err  = !reset && to_hit;
    end

    // Command FSM: latch on accept, drive gpio for one cycle, then return the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_id      <= '0;
            lat_lock    <= 1'b0;
            gpio_regSel <= '0;
            gpio_we     <= 1'b0;
            gpio_di     <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_ISSUE: begin
                    rsp_rdata   <= gpio_do;
                    rsp_valid   <= id_mask;
                    gpio_regSel <= '0;
                    gpio_we     <= 1'b0;
                    gpio_di     <= '0;
                    state       <= ST_RESP;
                end
                default: begin
                    if (accept) begin
                        gpio_regSel <= w_sel;
                        gpio_we     <= w_we;
                        gpio_di     <= w_wdata;
                        lat_id      <= win_idx;
                        lat_lock    <= w_lock;
                        state       <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Lock ownership, idle timeout and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
            owner  <= '0;
            to_cnt <= '0;
            rr_ptr <= '0;
        end else begin
            if (accept && !locked)
                rr_ptr <= rr_next(win_idx, N);

            if (accept && w_lock) begin
                locked <= 1'b1;
                owner  <= win_idx;
                to_cnt <= '0;
            end else if ((state == ST_RESP) && locked && !lat_lock) begin
                // Owner's final unlocking command has completed.
                locked <= 1'b0;
                to_cnt <= '0;
            end else if (to_hit) begin
                locked <= 1'b0;
                to_cnt <= '0;
            end else if (owner_acc) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter (N=2, LOCK_TIMEOUT=4) with a small GPIO register model.
module tb_gpio_arbiter;
    import gpio_arbiter_pkg::*;

    localparam logic [31:0] PINS_A = 32'h0000_00C3;
    localparam logic [31:0] PINS_B = 32'h0000_005A;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [5:0]  req_sel;
    logic [63:0] req_wdata;
    logic [1:0]  req_lock;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        lock_err;
    logic [2:0]  gpio_regSel;
    logic        gpio_we;
    logic [31:0] gpio_di;
    logic [31:0] gpio_do;

    logic [31:0] wr_a, dir_a, wr_b, dir_b;

    int    n_pass  = 0;
    int    n_total = 0;
    string sec     = "init";

    gpio_arbiter #(.N(2), .LOCK_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_sel     (req_sel),
        .req_wdata   (req_wdata),
        .req_lock    (req_lock),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .lock_err    (lock_err),
        .gpio_regSel (gpio_regSel),
        .gpio_we     (gpio_we),
        .gpio_di     (gpio_di),
        .gpio_do     (gpio_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO register model: writes on the clock edge, combinational read-back.
    always @(posedge clk) begin
        if (reset) begin
            wr_a <= '0; dir_a <= '0; wr_b <= '0; dir_b <= '0;
        end else if (gpio_we) begin
            case (gpio_regSel)
                SEL_WR_A:  wr_a  <= gpio_di;
                SEL_DIR_A: dir_a <= gpio_di;
                SEL_WR_B:  wr_b  <= gpio_di;
                SEL_DIR_B: dir_b <= gpio_di;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (gpio_regSel)
            SEL_WR_A:  gpio_do = wr_a;
            SEL_DIR_A: gpio_do = dir_a;
            SEL_RD_A:  gpio_do = PINS_A;
            SEL_WR_B:  gpio_do = wr_b;
            SEL_DIR_B: gpio_do = dir_b;
            SEL_RD_B:  gpio_do = PINS_B;
            default:   gpio_do = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s actual=%0h required=%0h (t=%0t)", sec, nm, act, exp, $time);
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance to the next falling edge.
    task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                        input logic [2:0] s0, input logic [31:0] d0,
                        input logic [2:0] s1, input logic [31:0] d1,
                        input logic [1:0] e_rdy, input logic e_we, input logic [1:0] e_rsp,
                        input logic e_err, input logic [31:0] e_rd);
        reset     = rst;
        req_valid = v;
        req_we    = w;
        req_lock  = lk;
        req_sel   = {s1, s0};
        req_wdata = {d1, d0};
        #1;
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("gpio_we",   64'(gpio_we),   64'(e_we));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("lock_err",  64'(lock_err),  64'(e_err));
        if (e_rsp != 2'b00) chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  w;
        logic [2:0]  s0;
        logic [31:0] d0;
        logic [2:0]  s1;
        logic [31:0] d1;
        logic [1:0]  e_rdy;
        logic [2:0]  e_sel;
        logic        e_we;
        logic [31:0] e_di;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single transactions from idle; expected winner follows the rr pointer left by the previous row.
        vecs[0] = '{2'b01, 2'b01, 3'd0, 32'hA5,       3'd0, 32'h0,        2'b01, 3'd0, 1'b1, 32'hA5,       32'h0};
        vecs[1] = '{2'b01, 2'b00, 3'd0, 32'h0,        3'd0, 32'h0,        2'b01, 3'd0, 1'b0, 32'h0,        32'hA5};
        vecs[2] = '{2'b11, 2'b00, 3'd1, 32'h0,        3'd2, 32'h0,        2'b10, 3'd2, 1'b0, 32'h0,        PINS_A};
        vecs[3] = '{2'b11, 2'b11, 3'd1, 32'hFF,       3'd4, 32'h11,       2'b01, 3'd1, 1'b1, 32'hFF,       32'h0};
        vecs[4] = '{2'b10, 2'b00, 3'd0, 32'h0,        3'd1, 32'h0,        2'b10, 3'd1, 1'b0, 32'h0,        32'hFF};
        vecs[5] = '{2'b10, 2'b10, 3'd0, 32'h0,        3'd5, 32'hDEAD,     2'b10, 3'd5, 1'b1, 32'hDEAD,     PINS_B};
        vecs[6] = '{2'b01, 2'b00, 3'd5, 32'h0,        3'd0, 32'h0,        2'b01, 3'd5, 1'b0, 32'h0,        PINS_B};
        vecs[7] = '{2'b11, 2'b10, 3'd0, 32'h0,        3'd3, 32'h12345678, 2'b10, 3'd3, 1'b1, 32'h12345678, 32'h0};
        vecs[8] = '{2'b01, 2'b00, 3'd3, 32'h0,        3'd0, 32'h0,        2'b01, 3'd3, 1'b0, 32'h0,        32'h12345678};

        reset = 1'b1; req_valid = '0; req_we = '0; req_lock = '0; req_sel = '0; req_wdata = '0;
        @(negedge clk);

        sec = "reset";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        chk("rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("gpio_regSel_di", {29'd0, gpio_regSel, gpio_di}, 64'h0);

        sec = "table";
        for (int i = 0; i < 9; i++) begin
            req_valid = vecs[i].v;
            req_we    = vecs[i].w;
            req_lock  = 2'b00;
            req_sel   = {vecs[i].s1, vecs[i].s0};
            req_wdata = {vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            chk($sformatf("v%0d_issue", i), {28'd0, gpio_regSel, gpio_we, gpio_di},
                {28'd0, vecs[i].e_sel, vecs[i].e_we, vecs[i].e_di});
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vecs[i].e_rd));
            @(negedge clk);
        end

        sec = "contention";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b01, 0, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b10, 0, 2'b01, 0, 32'h0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b01, 0, 2'b10, 0, 32'h0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h11, 3, 32'h22, 2'b10, 0, 2'b01, 0, 32'h11);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 32'h22);

        sec = "back2back";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 1, 32'hFF, 2'b10, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 32'h3C, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 32'h3C, 2'b10, 0, 2'b10, 0, 32'h0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 32'h0);
        chk("dir_a", 64'(dir_a), 64'hFF);
        chk("ports_a", 64'(wr_a[7:0]), 64'h3C);

        sec = "lock_rmw";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b11, 2'b10, 2'b01, 0, 0, 3, 32'h77, 2'b01, 0, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h5A, 3, 32'h77, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 2'b00, 0, 32'h5A, 3, 32'h77, 2'b01, 0, 2'b01, 0, 32'h0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 3, 32'h77, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 3, 32'h77, 2'b00, 0, 2'b01, 0, 32'h0);
        step(0, 2'b10, 2'b10, 2'b00, 0, 0, 3, 32'h77, 2'b10, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 32'h0);
        chk("rmw_wr_a", 64'(wr_a), 64'h5A);

        sec = "timeout";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b00, 0, 2'b01, 0, 32'h0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b00, 0, 2'b00, 1, 0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 5, 0, 2'b10, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, PINS_B);

        sec = "reset_issue";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b01, 2'b01, 2'b01, 1, 32'hF0, 0, 0, 2'b01, 0, 2'b00, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        chk("after_rst_rdata", 64'(rsp_rdata), 64'h0);
        chk("after_rst_gpio", {29'd0, gpio_regSel, gpio_di}, 64'h0);
        step(0, 2'b10, 2'b00, 2'b00, 0, 0, 2, 0, 2'b10, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, PINS_A);
        chk("dir_a_untouched", 64'(dir_a), 64'h0);

        sec = "reset_ptr";
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b01, 2'b01, 2'b00, 1, 32'h0F, 0, 0, 2'b01, 0, 2'b00, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0);
        step(0, 2'b11, 2'b00, 2'b00, 2, 0, 5, 0, 2'b01, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, PINS_A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
